// File: rtl/mac_dot_ctrl_if.sv
// mac_dot_ctrl_if: job request, operand-beat and result handshake bundle for mac_dot_ctrl
interface mac_dot_ctrl_if #(parameter int LEN_W = 16) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;

    modport master (
        output start, len, in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: sequences operand beats through an external 2-stage MAC cell and returns the dot product
module mac_dot_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_dot_ctrl_if.slave        bus,
    output logic [15:0]          mac_a,
    output logic [15:0]          mac_b,
    output logic [31:0]          mac_acc_in,
    input  logic [31:0]          mac_acc_out,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             first_flag_q, first_flag_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             accept;

    // Beat acceptance and datapath steering; idle cycles feed zero products,
    // and the first product of a job overwrites whatever the accumulator held.
    always_comb begin
        accept     = (state_q == RUN) && bus.in_valid;
        mac_a      = accept ? bus.in_a : 16'd0;
        mac_b      = accept ? bus.in_b : 16'd0;
        mac_acc_in = first_flag_q ? 32'd0 : mac_acc_out;
        bus.in_ready  = state_q == RUN;
        bus.res_valid = state_q == DONE;
        bus.res_data  = res_data_q;
        busy          = state_q != IDLE;
    end

    // Next-state logic: two drain cycles cover the multiply and accumulate registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        first_flag_d = 1'b0;
        res_data_d   = res_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = (bus.len != '0) ? RUN : DONE;
                    cnt_d      = bus.len;
                    pend_d     = bus.len != '0;
                    res_data_d = 32'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d        = cnt_q - LEN_W'(1);
                    pend_d       = 1'b0;
                    first_flag_d = pend_q;
                    state_d      = (cnt_q == LEN_W'(1)) ? DRAIN1 : RUN;
                end
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                state_d    = DONE;
                res_data_d = mac_acc_out;
            end
            DONE: state_d = bus.res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            first_flag_q <= 1'b0;
            res_data_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            first_flag_q <= first_flag_d;
            res_data_q   <= res_data_d;
        end
    end
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: directed jobs against a sum-of-products model with a 2-stage MAC cell stand-in
module tb_mac_dot_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mac_a, mac_b;
    logic [31:0] mac_acc_in, mac_acc_out;
    logic        busy;
    logic [31:0] prod_q = 32'hDEAD_BEEF;
    logic [31:0] acc_q  = 32'h1234_5678;
    logic [31:0] exp_res = 32'd0;
    logic [15:0] va [8];
    logic [15:0] vb [8];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mac_dot_ctrl_if #(.LEN_W(16)) bus ();

    mac_dot_ctrl #(.LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_acc_in  (mac_acc_in),
        .mac_acc_out (mac_acc_out),
        .busy        (busy)
    );

    // MAC cell: multiply register then accumulate register, deliberately not reset
    always @(posedge clk) begin
        prod_q <= 32'(mac_a) * 32'(mac_b);
        acc_q  <= mac_acc_in + prod_q;
    end
    assign mac_acc_out = acc_q;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("mac_a", 32'(mac_a), (bus.in_valid && bus.in_ready) ? 32'(bus.in_a) : 32'd0);
            check("mac_b", 32'(mac_b), (bus.in_valid && bus.in_ready) ? 32'(bus.in_b) : 32'd0);
            if (bus.res_valid) check("res_data_model", bus.res_data, exp_res);
            if (bus.in_ready || bus.res_valid) check("busy_active", 32'(busy), 32'd1);
        end
    end

    task automatic run_job(input int n, input bit gaps, input logic [31:0] lit, input int hold);
        logic [31:0] s;
        int          i, cyc, lat;
        bit          acc;
        s = 32'd0;
        for (int k = 0; k < n; k++) s += 32'(va[k]) * 32'(vb[k]);
        check("model_sum", s, lit);
        exp_res = s;
        bus.start = 1'b1;
        bus.len   = 16'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = 16'd0;
        if (n == 0) check("in_ready_len0", 32'(bus.in_ready), 32'd0);
        i = 0;
        cyc = 0;
        while (i < n && cyc < 200) begin
            bus.in_valid = !(gaps && cyc[0]);
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            if (!bus.in_valid) check("in_ready_gap", 32'(bus.in_ready), 32'd1);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_a     = 16'h5555;
        bus.in_b     = 16'hAAAA;
        if (i < n) check("beats_timeout", 32'(i), 32'(n));
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), (n == 0) ? 32'd1 : 32'd3);
        check("res_data", bus.res_data, lit);
        for (int h = 0; h < hold; h++) begin
            bus.start = 1'b1;
            bus.len   = 16'd3;
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", bus.res_data, lit);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = 16'd0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h5555;
        bus.in_b      = 16'hAAAA;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        rst = 1'b0;
        va[0] = 16'd1; va[1] = 16'd2; va[2] = 16'd3; va[3] = 16'd4;
        vb[0] = 16'd5; vb[1] = 16'd6; vb[2] = 16'd7; vb[3] = 16'd8;
        run_job(4, 1'b0, 32'd70, 0);
        run_job(4, 1'b1, 32'd70, 0);
        run_job(0, 1'b0, 32'd0, 0);
        va[0] = 16'hFFFF; va[1] = 16'hFFFF;
        vb[0] = 16'hFFFF; vb[1] = 16'hFFFF;
        run_job(2, 1'b0, 32'hFFFC_0002, 0);
        va[0] = 16'd3; vb[0] = 16'd4;
        run_job(1, 1'b0, 32'd12, 5);
        va[0] = 16'd1; va[1] = 16'd2;
        vb[0] = 16'd5; vb[1] = 16'd6;
        bus.start = 1'b1;
        bus.len   = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = va[k];
            bus.in_b     = vb[k];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_res_valid", 32'(bus.res_valid), 32'd0);
        check("arst_res_data", bus.res_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        va[0] = 16'd2; vb[0] = 16'd2;
        run_job(1, 1'b0, 32'd4, 0);
        va[0] = 16'd7; va[1] = 16'd9;
        vb[0] = 16'd11; vb[1] = 16'd13;
        run_job(2, 1'b1, 32'd194, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
